bcd_down_timer: RTL and testbench

Three-digit BCD countdown timer, the down-counting counterpart of the team's 3-digit BCD up-counter. It is loaded with a BCD value 000-999 and decrements once every TICK_DIV clocks after start. When the count reaches 000 it emits a one-cycle done pulse. Its bcd2/bcd1/bcd0 outputs use the same digit format as the up-counter, so both feed the same display path.

---
 rtl/bcd_down_timer.sv | 138 +++++++++++++
 tb/tb_bcd_down_timer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_timer.sv
// Three-digit BCD countdown timer with prescaled tick, pause/hold,
// sticky invalid-load flag and a one-cycle done pulse at 000.
module bcd_down_timer #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned DIV_W    = 16
) (
    input  logic       ck,
    input  logic       rs,
    input  logic       load,
    input  logic [3:0] ld_bcd2,
    input  logic [3:0] ld_bcd1,
    input  logic [3:0] ld_bcd0,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       running,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] PRE_TOP = DIV_W'(TICK_DIV - 1);
    localparam logic [11:0]      ONE     = 12'h001;

    state_t           state_q, state_d;
    logic [11:0]      val_q, val_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             run_q, run_d;

    logic [11:0]      ld_val;
    logic             ld_ok;
    logic             is_zero;

    // BCD minus one with borrow ripple; 000 is held, never wrapped.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] d2, d1, d0;
        d2 = v[11:8];
        d1 = v[7:4];
        d0 = v[3:0];
        if (v == 12'h000) begin
            return v;
        end
        if (d0 != 4'd0) begin
            d0 = d0 - 4'd1;
        end else begin
            d0 = 4'd9;
            if (d1 != 4'd0) begin
                d1 = d1 - 4'd1;
            end else begin
                d1 = 4'd9;
                d2 = d2 - 4'd1;
            end
        end
        return {d2, d1, d0};
    endfunction

    assign ld_val  = {ld_bcd2, ld_bcd1, ld_bcd0};
    assign ld_ok   = (ld_bcd2 <= 4'd9) && (ld_bcd1 <= 4'd9)
                  && (ld_bcd0 <= 4'd9);
    assign is_zero = (val_q == 12'h000);

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        pre_d   = pre_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (load) begin
            if (ld_ok) begin
                val_d   = ld_val;
                pre_d   = '0;
                state_d = IDLE;
                err_d   = 1'b0;
            end else begin
                err_d   = 1'b1;
            end
        end else if (start && state_q == IDLE) begin
            if (!is_zero) begin
                state_d = RUN;
                pre_d   = '0;
            end
        end else if (state_q == RUN) begin
            if (pause) begin
                state_d = HOLD;
            end else if (pre_q == PRE_TOP) begin
                pre_d = '0;
                val_d = bcd_dec(val_q);
                if (val_q == ONE) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end else begin
                pre_d = pre_q + DIV_W'(1);
            end
        end else if (state_q == HOLD) begin
            if (!pause) begin
                state_d = RUN;
            end
        end
    end

    assign run_d = (state_d == RUN) || (state_d == HOLD);

    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            state_q <= IDLE;
            val_q   <= 12'h000;
            pre_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            pre_q   <= pre_d;
            err_q   <= err_d;
            done_q  <= done_d;
            run_q   <= run_d;
        end
    end

    assign bcd2    = val_q[11:8];
    assign bcd1    = val_q[7:4];
    assign bcd0    = val_q[3:0];
    assign running = run_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed scoreboard bench for bcd_down_timer (TICK_DIV=4 and =1).
module tb_bcd_down_timer;

    logic        ck = 1'b0;
    logic        rs = 1'b0;

    logic        load4 = 1'b0, start4 = 1'b0, pause4 = 1'b0;
    logic [11:0] ld4 = 12'h000;
    logic [3:0]  o42, o41, o40;
    logic        run4, done4, err4;

    logic        load1 = 1'b0, start1 = 1'b0, pause1 = 1'b0;
    logic [11:0] ld1 = 12'h000;
    logic [3:0]  o12, o11, o10;
    logic        run1, done1, err1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        bit          sel;
        logic [14:0] exp;
    } exp_t;

    exp_t q[$];

    always #5 ck = ~ck;

    bcd_down_timer #(.TICK_DIV(4), .DIV_W(16)) dut4 (
        .ck(ck), .rs(rs), .load(load4),
        .ld_bcd2(ld4[11:8]), .ld_bcd1(ld4[7:4]), .ld_bcd0(ld4[3:0]),
        .start(start4), .pause(pause4),
        .bcd2(o42), .bcd1(o41), .bcd0(o40),
        .running(run4), .done(done4), .err(err4)
    );

    bcd_down_timer #(.TICK_DIV(1), .DIV_W(16)) dut1 (
        .ck(ck), .rs(rs), .load(load1),
        .ld_bcd2(ld1[11:8]), .ld_bcd1(ld1[7:4]), .ld_bcd0(ld1[3:0]),
        .start(start1), .pause(pause1),
        .bcd2(o12), .bcd1(o11), .bcd0(o10),
        .running(run1), .done(done1), .err(err1)
    );

    function automatic logic [11:0] bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic expect_v(input string tag, input bit sel, input int n,
                            input logic r, input logic d, input logic e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = {bcd(n), r, d, e};
        q.push_back(x);
    endtask

    task automatic check();
        exp_t x;
        logic [14:0] obs;
        while (q.size() > 0) begin
            x = q.pop_front();
            obs = x.sel ? {o12, o11, o10, run1, done1, err1}
                        : {o42, o41, o40, run4, done4, err4};
            vectors++;
            assert (obs === x.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic step4(input string tag, input int n, input logic r,
                         input logic d, input logic e);
        expect_v(tag, 1'b0, n, r, d, e);
        cyc();
        check();
    endtask

    initial begin
        #3;
        expect_v("rst4", 1'b0, 0, 0, 0, 0);
        expect_v("rst1", 1'b1, 0, 0, 0, 0);
        check();
        cyc();
        rs = 1'b1;
        step4("idle_after_rst", 0, 0, 0, 0);

        // TICK_DIV=1 full 100 -> 000 run
        ld1 = bcd(100);
        load1 = 1'b1;
        expect_v("t1_load", 1'b1, 100, 0, 0, 0);
        cyc();
        check();
        load1 = 1'b0;
        start1 = 1'b1;
        expect_v("t1_start", 1'b1, 100, 1, 0, 0);
        cyc();
        check();
        start1 = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            expect_v("t1_cnt", 1'b1, 100 - k, k < 100, k == 100, 0);
            cyc();
            check();
        end
        expect_v("t1_after", 1'b1, 0, 0, 0, 0);
        cyc();
        check();

        // TICK_DIV=4: 003 down to 000
        ld4 = bcd(3);
        load4 = 1'b1;
        step4("t2_load", 3, 0, 0, 0);
        load4 = 1'b0;
        start4 = 1'b1;
        step4("t2_start", 3, 1, 0, 0);
        start4 = 1'b0;
        for (int k = 1; k <= 12; k++)
            step4("t2_cnt", 3 - k / 4, k < 12, k == 12, 0);
        step4("t2_after", 0, 0, 0, 0);

        // 010 -> 009 borrow
        ld4 = bcd(10);
        load4 = 1'b1;
        step4("t2b_load", 10, 0, 0, 0);
        load4 = 1'b0;
        start4 = 1'b1;
        step4("t2b_start", 10, 1, 0, 0);
        start4 = 1'b0;
        for (int k = 1; k <= 4; k++)
            step4("t2b_cnt", 10 - k / 4, 1, 0, 0);

        // Pause with two ticks already elapsed
        ld4 = bcd(50);
        load4 = 1'b1;
        step4("t3_abort_load", 50, 0, 0, 0);
        load4 = 1'b0;
        start4 = 1'b1;
        step4("t3_start", 50, 1, 0, 0);
        start4 = 1'b0;
        step4("t3_tick1", 50, 1, 0, 0);
        step4("t3_tick2", 50, 1, 0, 0);
        pause4 = 1'b1;
        for (int k = 0; k < 20; k++)
            step4("t3_hold", 50, 1, 0, 0);
        pause4 = 1'b0;
        step4("t3_release", 50, 1, 0, 0);
        step4("t3_rel_p1", 50, 1, 0, 0);
        step4("t3_rel_p2", 49, 1, 0, 0);

        // Invalid load, sticky err, start at 000
        ld4 = bcd(123);
        load4 = 1'b1;
        step4("t4_abort", 123, 0, 0, 0);
        ld4 = 12'h2A5;
        step4("t4_bad", 123, 0, 0, 1);
        load4 = 1'b0;
        step4("t4_sticky", 123, 0, 0, 1);
        ld4 = bcd(205);
        load4 = 1'b1;
        step4("t4_good", 205, 0, 0, 0);
        ld4 = bcd(0);
        step4("t4_zero", 0, 0, 0, 0);
        load4 = 1'b0;
        start4 = 1'b1;
        step4("t4_start0", 0, 0, 0, 0);
        start4 = 1'b0;
        step4("t4_start0_p1", 0, 0, 0, 0);

        // Load+start together, start in RUN, load mid-run
        ld4 = bcd(7);
        load4 = 1'b1;
        start4 = 1'b1;
        step4("t5_ldst", 7, 0, 0, 0);
        load4 = 1'b0;
        start4 = 1'b0;
        for (int k = 0; k < 4; k++)
            step4("t5_idle", 7, 0, 0, 0);
        start4 = 1'b1;
        step4("t5_start", 7, 1, 0, 0);
        start4 = 1'b0;
        for (int k = 1; k <= 8; k++)
            step4("t5_cnt", 7 - k / 4, 1, 0, 0);
        start4 = 1'b1;
        step4("t5_restart", 5, 1, 0, 0);
        start4 = 1'b0;
        for (int k = 10; k <= 12; k++)
            step4("t5_norestart", 7 - k / 4, 1, 0, 0);
        ld4 = bcd(9);
        load4 = 1'b1;
        step4("t5_midload", 9, 0, 0, 0);
        load4 = 1'b0;
        for (int k = 0; k < 3; k++)
            step4("t5_after", 9, 0, 0, 0);

        // Asynchronous reset mid-countdown with err set
        ld4 = bcd(123);
        load4 = 1'b1;
        step4("t6_load", 123, 0, 0, 0);
        ld4 = 12'h1F3;
        step4("t6_bad", 123, 0, 0, 1);
        load4 = 1'b0;
        start4 = 1'b1;
        step4("t6_start", 123, 1, 0, 1);
        start4 = 1'b0;
        step4("t6_run", 123, 1, 0, 1);
        @(posedge ck);
        #3;
        rs = 1'b0;
        #1;
        expect_v("t6_async", 1'b0, 0, 0, 0, 0);
        check();
        step4("t6_held", 0, 0, 0, 0);
        rs = 1'b1;
        for (int k = 0; k < 5; k++)
            step4("t6_quiet", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
